// File: rtl/tx_address_queue_pkg.sv
// tx_address_queue_pkg
// Shared definitions for the transmit address queue:
//   MAC_W_DEFAULT - default width of one MAC address field
//   tx_addr_t     - one queue entry {src, dst} at the default width
//   ptr_w_t/ptr_w - pointer width (index bits plus a wrap bit) for a given depth;
//                   the occupancy port uses the same width
package tx_address_queue_pkg;

  localparam int MAC_W_DEFAULT = 48;

  typedef struct packed {
    logic [MAC_W_DEFAULT-1:0] src;
    logic [MAC_W_DEFAULT-1:0] dst;
  } tx_addr_t;

  typedef int unsigned ptr_w_t;

  function automatic ptr_w_t ptr_w(input int unsigned depth);
    return ptr_w_t'($clog2(depth) + 1);
  endfunction

endpackage

// File: rtl/tx_addr_ram.sv
// tx_addr_ram
// Address-pair storage for the transmit address queue: 2**AW words of DW bits,
// synchronous write, asynchronous read.
// Ports:
//   clk   - write clock
//   we    - write enable
//   waddr - write index
//   wdata - write word {src, dst}
//   raddr - read index
//   rdata - word at raddr (combinational)
module tx_addr_ram #(
  parameter int AW = 2,
  parameter int DW = 96
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] r_mem [0:(1<<AW)-1];

  always_ff @(posedge clk) begin
    if (we) r_mem[waddr] <= wdata;
  end

  assign rdata = r_mem[raddr];

endmodule

// File: rtl/tx_address_queue.sv
// tx_address_queue
// DEPTH-entry FIFO of {src, dst} MAC address pairs between the header builder
// and the transmit framer, with flush, occupancy, saturating overflow counter
// and first-word-fall-through registered head outputs.
// Optional feature macro: TX_ADDR_SRC_OVERRIDE_EN (stored src taken from
// local_src when src_ovr is high in the write cycle).
// Ports:
//   clk, rst            - clock, synchronous active-high reset
//   wr_valid/wr_ready   - write handshake (wr_ready = not full, registered)
//   wr_src, wr_dst      - address pair to enqueue
//   rd_valid/rd_ready   - read handshake for the head entry
//   rd_src, rd_dst      - registered head entry, held while rd_valid is low
//   flush               - discards all entries
//   count               - current occupancy
//   ovf_cnt             - saturating count of writes dropped while full
//   local_src, src_ovr  - source override (only with the macro)
module tx_address_queue
  import tx_address_queue_pkg::*;
#(
  parameter int MAC_W = MAC_W_DEFAULT,
  parameter int DEPTH = 4,
  parameter int CNT_W = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_valid,
  output logic                     wr_ready,
  input  logic [MAC_W-1:0]         wr_src,
  input  logic [MAC_W-1:0]         wr_dst,
  output logic                     rd_valid,
  input  logic                     rd_ready,
  output logic [MAC_W-1:0]         rd_src,
  output logic [MAC_W-1:0]         rd_dst,
  input  logic                     flush,
  output logic [ptr_w(DEPTH)-1:0]  count,
  output logic [CNT_W-1:0]         ovf_cnt,
  input  logic [MAC_W-1:0]         local_src,
  input  logic                     src_ovr
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  logic [PW-1:0]      r_wptr, r_rptr;
  logic               r_wr_ready, r_rd_valid;
  logic [MAC_W-1:0]   r_rd_src, r_rd_dst;
  logic [CNT_W-1:0]   r_ovf;

  logic               w_wr, w_pop, w_drop;
  logic [PW-1:0]      w_wptr_n, w_rptr_n, w_count_n;
  logic [MAC_W-1:0]   w_src;
  logic [2*MAC_W-1:0] w_wdata, w_rdata, w_head_n;

`ifdef TX_ADDR_SRC_OVERRIDE_EN
  assign w_src = src_ovr ? local_src : wr_src;
`else
  assign w_src = wr_src;
  logic w_unused_ovr;
  assign w_unused_ovr = ^{local_src, src_ovr};
`endif

  assign w_wr      = wr_valid && r_wr_ready;
  assign w_pop     = r_rd_valid && rd_ready;
  assign w_drop    = wr_valid && !r_wr_ready;
  assign w_wptr_n  = r_wptr + PW'(w_wr);
  assign w_rptr_n  = r_rptr + PW'(w_pop);
  assign w_count_n = w_wptr_n - w_rptr_n;
  assign w_wdata   = {w_src, wr_dst};

  // The RAM is read at the post-update read pointer so the head register
  // loads the entry that will be at the front after this edge.
  tx_addr_ram #(.AW(AW), .DW(2*MAC_W)) u_ram (
    .clk   (clk),
    .we    (w_wr),
    .waddr (r_wptr[AW-1:0]),
    .wdata (w_wdata),
    .raddr (w_rptr_n[AW-1:0]),
    .rdata (w_rdata)
  );

  // If the new head is the slot being written this cycle, the RAM does not
  // hold it yet, so take the incoming pair directly.
  assign w_head_n = (w_wr && (w_rptr_n == r_wptr)) ? w_wdata : w_rdata;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_wr_ready <= 1'b1;
      r_rd_valid <= 1'b0;
      r_rd_src   <= '0;
      r_rd_dst   <= '0;
      r_ovf      <= '0;
    end else if (flush) begin
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_wr_ready <= 1'b1;
      r_rd_valid <= 1'b0;
    end else begin
      r_wptr     <= w_wptr_n;
      r_rptr     <= w_rptr_n;
      r_wr_ready <= (w_count_n != PW'(DEPTH));
      r_rd_valid <= (w_count_n != '0);
      if (w_count_n != '0) {r_rd_src, r_rd_dst} <= w_head_n;
      if (w_drop && (r_ovf != '1)) r_ovf <= r_ovf + CNT_W'(1);
    end
  end

  assign wr_ready = r_wr_ready;
  assign rd_valid = r_rd_valid;
  assign rd_src   = r_rd_src;
  assign rd_dst   = r_rd_dst;
  assign count    = r_wptr - r_rptr;
  assign ovf_cnt  = r_ovf;

endmodule

// File: tb/tb_tx_address_queue.sv
module tb_tx_address_queue;
  import tx_address_queue_pkg::*;

  localparam int DEPTH = 4;

  logic        clk;
  logic        rst, wr_valid, rd_ready, flush, src_ovr;
  logic [47:0] wr_src, wr_dst, local_src;

  logic        wr_ready, rd_valid, wr_ready2, rd_valid2;
  logic [47:0] rd_src, rd_dst, rd_src2, rd_dst2;
  logic [2:0]  count, count2;
  logic [7:0]  ovf_cnt;
  logic [1:0]  ovf_cnt2;

  int total = 0;
  int bad   = 0;

  // reference model: ordered list of queued pairs, overflow tally, last head
  tx_addr_t q[$];
  tx_addr_t last;
  int       ovf;

  tx_address_queue #(.MAC_W(48), .DEPTH(DEPTH), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .wr_src(wr_src), .wr_dst(wr_dst), .rd_valid(rd_valid), .rd_ready(rd_ready),
    .rd_src(rd_src), .rd_dst(rd_dst), .flush(flush), .count(count),
    .ovf_cnt(ovf_cnt), .local_src(local_src), .src_ovr(src_ovr)
  );

  tx_address_queue #(.MAC_W(48), .DEPTH(DEPTH), .CNT_W(2)) dut2 (
    .clk(clk), .rst(rst), .wr_valid(wr_valid), .wr_ready(wr_ready2),
    .wr_src(wr_src), .wr_dst(wr_dst), .rd_valid(rd_valid2), .rd_ready(rd_ready),
    .rd_src(rd_src2), .rd_dst(rd_dst2), .flush(flush), .count(count2),
    .ovf_cnt(ovf_cnt2), .local_src(local_src), .src_ovr(src_ovr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end

  function automatic logic [47:0] rnd48();
    logic [47:0] r;
    r = {16'($urandom()), $urandom()};
    return r;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    int sz;
    sz = q.size();
    chk({tag, " rd_valid"}, 64'(rd_valid), 64'(sz > 0));
    chk({tag, " wr_ready"}, 64'(wr_ready), 64'(sz < DEPTH));
    chk({tag, " count"},    64'(count),    64'(sz));
    chk({tag, " ovf_cnt"},  64'(ovf_cnt),  64'((ovf > 255) ? 255 : ovf));
    chk({tag, " rd_src"},   64'(rd_src),   64'(last.src));
    chk({tag, " rd_dst"},   64'(rd_dst),   64'(last.dst));
    chk({tag, " rd_valid2"}, 64'(rd_valid2), 64'(sz > 0));
    chk({tag, " wr_ready2"}, 64'(wr_ready2), 64'(sz < DEPTH));
    chk({tag, " count2"},   64'(count2),   64'(sz));
    chk({tag, " ovf_cnt2"}, 64'(ovf_cnt2), 64'((ovf > 3) ? 3 : ovf));
    chk({tag, " rd_src2"},  64'(rd_src2),  64'(last.src));
    chk({tag, " rd_dst2"},  64'(rd_dst2),  64'(last.dst));
  endtask

  task automatic drive(input bit wv, input bit rr, input bit fl,
                       input logic [47:0] s, input logic [47:0] d);
    wr_valid = wv;
    rd_ready = rr;
    flush    = fl;
    wr_src   = s;
    wr_dst   = d;
  endtask

  // one clock edge: advance the model with the inputs presented, then check
  task automatic tick(input string tag);
    tx_addr_t e;
    bit full, acc, pp;
    @(posedge clk);
    if (rst) begin
      q.delete();
      ovf  = 0;
      last = '0;
    end else if (flush) begin
      q.delete();
    end else begin
      full = (q.size() == DEPTH);
      acc  = wr_valid && !full;
      pp   = rd_ready && (q.size() > 0);
      if (wr_valid && full) ovf++;
      e.dst = wr_dst;
`ifdef TX_ADDR_SRC_OVERRIDE_EN
      e.src = src_ovr ? local_src : wr_src;
`else
      e.src = wr_src;
`endif
      if (pp) void'(q.pop_front());
      if (acc) q.push_back(e);
    end
    if (q.size() > 0) last = q[0];
    #1;
    check_all(tag);
  endtask

  initial begin
    q.delete();
    last = '0;
    ovf  = 0;
    rst = 1'b1; src_ovr = 1'b0; local_src = '0;
    drive(0, 0, 0, '0, '0);

    // reset
    tick("reset");
    tick("reset2");
    rst = 1'b0;

    // single write then pop
    drive(1, 0, 0, 48'h001122334455, 48'hAABBCCDDEEFF);
    tick("single_wr");
    drive(0, 1, 0, '0, '0);
    tick("single_pop");
    drive(0, 0, 0, '0, '0);
    tick("single_idle");

    // fill past full, then drain in order
    for (int i = 0; i < 5; i++) begin
      drive(1, 0, 0, rnd48(), rnd48());
      tick("fill");
    end
    drive(0, 1, 0, '0, '0);
    for (int i = 0; i < 5; i++) tick("drain");

    // streaming at count=2 across pointer wrap
    for (int i = 0; i < 2; i++) begin
      drive(1, 0, 0, rnd48(), rnd48());
      tick("stream_pre");
    end
    for (int i = 0; i < 16; i++) begin
      drive(1, 1, 0, rnd48(), rnd48());
      tick("stream");
    end
    drive(0, 1, 0, '0, '0);
    for (int i = 0; i < 3; i++) tick("stream_drain");

    // full with simultaneous write and pop: write refused
    for (int i = 0; i < 4; i++) begin
      drive(1, 0, 0, rnd48(), rnd48());
      tick("full_fill");
    end
    drive(1, 1, 0, rnd48(), rnd48());
    tick("full_wr_pop");
    tick("full_wr_pop2");

    // flush with write at count=3
    drive(1, 0, 1, rnd48(), rnd48());
    tick("flush");
    drive(0, 0, 0, '0, '0);
    tick("flush_idle");

    // source override
    src_ovr   = 1'b1;
    local_src = 48'h020000000001;
    drive(1, 0, 0, 48'h0A0A0A0A0A0A, rnd48());
    tick("override");
    src_ovr = 1'b0;
    drive(0, 1, 0, '0, '0);
    tick("override_pop");

    // randomized traffic
    for (int i = 0; i < 300; i++) begin
      rst       = ($urandom_range(0, 59) == 0);
      src_ovr   = 1'($urandom_range(0, 1));
      local_src = rnd48();
      drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            ($urandom_range(0, 15) == 0), rnd48(), rnd48());
      tick("random");
    end
    rst = 1'b0; src_ovr = 1'b0;

    // overflow saturation then reset
    rst = 1'b1;
    drive(0, 0, 0, '0, '0);
    tick("sat_reset");
    rst = 1'b0;
    for (int i = 0; i < 11; i++) begin
      drive(1, 0, 0, rnd48(), rnd48());
      tick("sat_fill");
    end
    rst = 1'b1;
    drive(1, 1, 0, rnd48(), rnd48());
    tick("final_reset");
    rst = 1'b0;
    drive(0, 0, 0, '0, '0);
    tick("final_idle");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/tx_address_queue.md
# tx_address_queue

Parametrised multi-entry successor to the single transmit address register. It queues per-frame destination/source MAC address pairs from the header builder, DEPTH entries deep, and presents them to the transmit framer on a valid/ready interface. Several headers can therefore be accepted while the framer is still sending earlier frames. It also adds flush, occupancy reporting, overflow accounting and an optional local source-address override.

## Interface
Parameters:
- MAC_W, 48, width of each MAC address field.
- DEPTH, 4, number of queued address pairs; power of two, at least 2.
- CNT_W, 8, width of the saturating overflow counter.

Ports:
- clk  in  1  sole clock; all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- wr_valid  in  1  header builder presents an address pair.
- wr_ready  out  1  queue can accept; registered, equals not-full.
- wr_src  in  MAC_W  source MAC address.
- wr_dst  in  MAC_W  destination MAC address.
- rd_valid  out  1  head entry available to the framer.
- rd_ready  in  1  framer consumes the head entry.
- rd_src  out  MAC_W  head source address; registered.
- rd_dst  out  MAC_W  head destination address; registered.
- flush  in  1  discards all entries.
- count  out  $clog2(DEPTH)+1  current occupancy.
- ovf_cnt  out  CNT_W  saturating count of writes dropped while full.
- local_src  in  MAC_W  local station address; used only with the override macro.
- src_ovr  in  1  selects local_src in place of wr_src; used only with the override macro.

## Operation
- Storage is a circular buffer of DEPTH entries, each entry {src, dst}.
- Pointers are $clog2(DEPTH)+1 bits with a wrap bit:
  - empty: pointers equal.
  - full: pointers differ only in the MSB.
- A write occurs when wr_valid && wr_ready.
- wr_valid while full is a dropped write:
  - no state change;
  - ovf_cnt increments, saturating at all-ones.
- A pop occurs when rd_valid && rd_ready.
- rd_src and rd_dst always show the head entry (first-word fall-through); they hold their value while rd_valid is low.
- Write and pop in the same cycle:
  - both take effect;
  - count is unchanged.
- Write and pop on a full queue in the same cycle: the write is still refused, because wr_ready reflects the previous cycle's full state; ovf_cnt increments.
- Write on an empty queue with rd_ready high: the entry becomes visible on the next cycle; there is no same-cycle bypass.
- Priority is rst > flush > write/pop. Flush:
  - clears both pointers and count;
  - deasserts rd_valid on the next cycle;
  - ignores any write or pop in the same cycle;
  - leaves ovf_cnt unchanged.
- Reset values:
  - wr_ready=1, rd_valid=0, rd_src=0, rd_dst=0;
  - count=0, ovf_cnt=0, pointers=0.

## Timing
- Write to rd_valid latency: 1 cycle. A write at edge N makes rd_valid high after edge N (empty queue case).
- Pop to next head on rd_src/rd_dst: 1 cycle; back-to-back pops at 1 entry/cycle are sustained.
- Writes are sustained at 1 entry/cycle until full.
- wr_ready falls the cycle after the write that fills the queue. It rises the cycle after the first pop from full.
- rd_valid falls the cycle after the pop of the last entry, unless a write occurred in that same cycle.
- Full throughput: a queue at count=DEPTH-1 with simultaneous write and pop stays at DEPTH-1 indefinitely.
- A reset asserted mid-stream clears all state at that edge; entries in flight are lost and are not counted as overflow.

## Configuration
- TX_ADDR_SRC_OVERRIDE_EN defined:
  - on each accepted write, the stored src is local_src when src_ovr=1, else wr_src;
  - the selection is sampled in the write cycle.
- Not defined:
  - local_src and src_ovr are ignored;
  - src is always wr_src;
  - no override mux is synthesised.

## Structure
- Shared package defines:
  - MAC_W_DEFAULT;
  - the packed struct tx_addr_t {src, dst};
  - the typedef of the pointer-width function used by count.
- Sub-module tx_addr_ram: DEPTH x 2*MAC_W storage with a synchronous write port and an asynchronous read port indexed by the read pointer. The top level owns the pointers, flags, counters and output registers.

## Test plan
- Reset, then a single write of src=0x001122334455, dst=0xAABBCCDDEEFF: rd_valid high one cycle later with matching outputs, count=1; pop leaves count=0 and rd_valid low next cycle.
- DEPTH=4: write 5 entries with rd_ready=0. After the 4th write wr_ready=0 and count=4; the 5th is dropped and ovf_cnt=1. Draining returns entries 1-4 in order.
- Continuous simultaneous write and pop at count=2 for 16 cycles: count stays 2 and the output order matches the input order across pointer wrap.
- Flush asserted together with wr_valid at count=3: next cycle count=0, rd_valid=0, wr_ready=1, ovf_cnt unchanged.
- With the macro defined: write wr_src=0x0A0A0A0A0A0A, local_src=0x020000000001, src_ovr=1 gives rd_src=0x020000000001. With the macro undefined, the same stimulus gives rd_src=0x0A0A0A0A0A0A.
- CNT_W=2: seven writes while full give ovf_cnt=3 (saturated); rst then returns every output to its reset value.
